// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: CPU request/response and RAM port bundle for mem_ctrl.
// master = CPU plus RAM side (the environment), slave = the controller.
interface mem_ctrl_if #(
    parameter int ADDR_SIZE = 16,
    parameter int DATA_SIZE = 16
);
    logic                 req;
    logic                 rw;
    logic [ADDR_SIZE-1:0] mar_in;
    logic [DATA_SIZE-1:0] mdr_in;
    logic [DATA_SIZE-1:0] mdr_out;
    logic                 ready;
    logic                 busy;
    logic                 ram_we;
    logic [ADDR_SIZE-1:0] ram_addr;
    logic [DATA_SIZE-1:0] ram_din;
    logic [DATA_SIZE-1:0] ram_dout;

    modport master (
        output req, rw, mar_in, mdr_in, ram_dout,
        input  mdr_out, ready, busy, ram_we, ram_addr, ram_din
    );
    modport slave (
        input  req, rw, mar_in, mdr_in, ram_dout,
        output mdr_out, ready, busy, ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: LC-3 style RAM access sequencer (IDLE -> SETUP -> ACCESS x N -> DONE).
// All outputs come straight from registers so RAM_WE and the address are glitch-free.
module mem_ctrl #(
    parameter int ADDR_SIZE   = 16,
    parameter int DATA_SIZE   = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    mem_ctrl_if.slave    bus
);
    localparam int WC = (WAIT_CYCLES == 0) ? 1 : WAIT_CYCLES;
    localparam int CW = $clog2(WC + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t               r_state, w_next;
    logic [CW-1:0]        r_cnt, w_cnt;
    logic                 r_wr, r_we, w_we;
    logic [ADDR_SIZE-1:0] r_addr;
    logic [DATA_SIZE-1:0] r_din, r_mdr;
    logic                 w_accept, w_capture;

    assign w_accept  = (r_state == IDLE) && bus.req;
    assign w_capture = (r_state == ACCESS) && (r_cnt == CW'(1)) && !r_wr;

    always_comb begin
        w_next = r_state;
        w_cnt  = r_cnt;
        w_we   = 1'b0;
        case (r_state)
            IDLE:   w_next = bus.req ? SETUP : IDLE;
            SETUP: begin
                w_next = ACCESS;
                w_cnt  = CW'(WC);
                w_we   = r_wr;
            end
            ACCESS: begin
                // RAM_WE stays up for every ACCESS cycle except the one after the last edge
                w_next = (r_cnt == CW'(1)) ? DONE : ACCESS;
                w_cnt  = (r_cnt == CW'(1)) ? r_cnt : r_cnt - CW'(1);
                w_we   = (r_cnt == CW'(1)) ? 1'b0 : r_wr;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
            r_mdr   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            r_we    <= w_we;
            if (w_accept) begin
                r_addr <= bus.mar_in;
                r_din  <= bus.mdr_in;
                r_wr   <= bus.rw;
            end
            if (w_capture)
                r_mdr <= bus.ram_dout;
        end
    end

    assign bus.busy     = r_state != IDLE;
    assign bus.ready    = r_state == DONE;
    assign bus.ram_we   = r_we;
    assign bus.ram_addr = r_addr;
    assign bus.ram_din  = r_din;
    assign bus.mdr_out  = r_mdr;
endmodule
